dds_spi_cfg: RTL and testbench

SPI-mode-0 configuration responder for the DDS synthesizer: receives 24-bit frames from an external host on the dedicated input pins and drives the DDS control registers (32-bit frequency tuning word, phase offset, waveform select, enable). It is the receiving end of the host configuration link. It sits between the pin-level `ui_in`/`uio` interface and the phase accumulator / waveform stage, with an optional MISO readback path on a bidirectional pin.

---
 rtl/dds_spi_cfg.sv | 223 ++++++++++++++++++++++
 tb/tb_dds_spi_cfg.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dds_spi_cfg.sv
// dds_spi_cfg
// SPI mode-0 configuration responder for the DDS synthesizer. A host sends
// 24-bit frames, MSB first: bit 23 = R/W (1 = read), bits 22:16 = address,
// bits 15:0 = data. Writes land in the DDS control registers only when the
// 24th bit arrives. Reads shift the addressed register out on miso during
// data bits 9-24.
//
// Register map:
//   0x00 FTW_LO    staged low half of the tuning word (reads back staged value)
//   0x01 FTW_HI    commits {HI, staged LO} to ftw and pulses ftw_update
//   0x02 CTRL      [1:0] wave_sel, [2] dds_en, other bits read 0
//   0x03 PHASE_OFS
//   others         writes ignored, reads return 0
//
// Ports:
//   clk, rst            system clock, asynchronous active-high reset
//   sclk, cs_n, mosi    SPI pins from the host, asynchronous to clk
//   miso, miso_oe       readback data and its pin output enable
//   ftw, ftw_update     tuning word and its one-cycle change pulse
//   phase_ofs           phase offset
//   wave_sel, dds_en    waveform select and run enable
//
// state | meaning
// ------+--------------------------------------------
// IDLE  | cs_n high, or waiting for a fresh cs_n fall
// CMD   | receiving bits 1-8 (R/W + address)
// DATA  | receiving bits 9-24 (data), miso active on reads
// DONE  | 24 bits received, later bits ignored until cs_n high

module dds_spi_cfg #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sclk,
  input  logic        cs_n,
  input  logic        mosi,
  output logic        miso,
  output logic        miso_oe,
  output logic [31:0] ftw,
  output logic        ftw_update,
  output logic [15:0] phase_ofs,
  output logic [1:0]  wave_sel,
  output logic        dds_en
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state, state_next;

  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   sclk_d;
  logic                   cs_d;
  logic                   sclk_s;
  logic                   cs_s;
  logic                   mosi_s;
  logic                   sclk_rise;
  logic                   sclk_fall;
  logic                   cs_fall;

  logic [SYNC_STAGES:0]   fill;
  logic                   armed;

  logic [4:0]             bit_cnt;
  logic [22:0]            shreg;
  logic [23:0]            frame_next;
  logic [15:0]            out_sh;
  logic [15:0]            ftw_lo;
  logic [15:0]            rd_mux;
  logic                   sample;
  logic                   last_cmd;
  logic                   last_bit;

  // Input synchronizers; reset values model an idle bus (cs_n high).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      sclk_d    <= 1'b0;
      cs_d      <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      sclk_d    <= sclk_s;
      cs_d      <= cs_s;
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;

  // The synchronizer resets to cs_n high, so a pin held low through reset
  // would look like a falling edge once the chain refills. Frames are only
  // accepted after cs_n has genuinely been seen high with a full chain, so a
  // frame interrupted by reset is discarded until the next real cs_n fall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill  <= '0;
      armed <= 1'b0;
    end else begin
      fill  <= {fill[SYNC_STAGES-1:0], 1'b1};
      armed <= armed | (fill[SYNC_STAGES] & cs_s & cs_d);
    end
  end

  assign cs_fall = ~cs_s & cs_d & armed;

  // A bit is sampled whenever a frame is in progress. The state lags cs_n by
  // one cycle, so a 24th sclk rise detected together with the cs_n rise is
  // still taken and commits.
  assign sample     = sclk_rise & ((state == CMD) | (state == DATA));
  assign last_cmd   = sample & (bit_cnt == 5'd7);
  assign last_bit   = sample & (bit_cnt == 5'd23);
  assign frame_next = {shreg, mosi_s};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (cs_fall) state_next = CMD;
      CMD: begin
        if (cs_s)          state_next = IDLE;
        else if (last_cmd) state_next = DATA;
      end
      DATA: begin
        if (cs_s)          state_next = IDLE;
        else if (last_bit) state_next = DONE;
      end
      DONE: if (cs_s) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Bit counter: held at zero in IDLE, so it is clear when the frame starts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt <= 5'd0;
    end else if (state == IDLE) begin
      bit_cnt <= 5'd0;
    end else if (sample && bit_cnt != 5'd24) begin
      bit_cnt <= bit_cnt + 5'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) shreg <= '0;
    else if (sample) shreg <= frame_next[22:0];
  end

  // Readback mux, addressed by the seven address bits as they complete.
  always_comb begin
    rd_mux = 16'h0000;
    case (frame_next[6:0])
      7'h00: rd_mux = ftw_lo;
      7'h01: rd_mux = ftw[31:16];
      7'h02: rd_mux = {13'd0, dds_en, wave_sel};
      7'h03: rd_mux = phase_ofs;
      default: rd_mux = 16'h0000;
    endcase
  end

  // Output shifter: loaded after bit 8 (cleared on writes so miso stays 0).
  // The first sclk fall in DATA precedes the host's bit-9 sample, so shifting
  // starts only from the fall that follows bit 9.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_sh <= '0;
    end else if (last_cmd) begin
      out_sh <= frame_next[7] ? rd_mux : 16'h0000;
    end else if ((state == DATA) && sclk_fall && (bit_cnt != 5'd8)) begin
      out_sh <= {out_sh[14:0], 1'b0};
    end
  end

  // Register commit on the 24th bit of a write frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ftw        <= '0;
      ftw_lo     <= '0;
      phase_ofs  <= '0;
      wave_sel   <= '0;
      dds_en     <= 1'b0;
      ftw_update <= 1'b0;
    end else begin
      ftw_update <= 1'b0;
      if (last_bit && !frame_next[23]) begin
        case (frame_next[22:16])
          7'h00: ftw_lo <= frame_next[15:0];
          7'h01: begin
            ftw        <= {frame_next[15:0], ftw_lo};
            ftw_update <= 1'b1;
          end
          7'h02: begin
            wave_sel <= frame_next[1:0];
            dds_en   <= frame_next[2];
          end
          7'h03: phase_ofs <= frame_next[15:0];
          default: ;
        endcase
      end
    end
  end

  assign miso    = (state == DATA) & out_sh[15];
  assign miso_oe = ~cs_s;

endmodule

// File: tb/tb_dds_spi_cfg.sv
`timescale 1ns/1ps
module tb_dds_spi_cfg;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sclk = 1'b0;
  logic        cs_n = 1'b1;
  logic        mosi = 1'b0;
  logic        miso;
  logic        miso_oe;
  logic [31:0] ftw;
  logic        ftw_update;
  logic [15:0] phase_ofs;
  logic [1:0]  wave_sel;
  logic        dds_en;

  always #5 clk = ~clk;

  dds_spi_cfg #(.SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .ftw(ftw), .ftw_update(ftw_update),
    .phase_ofs(phase_ofs), .wave_sel(wave_sel), .dds_en(dds_en)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: register contents as the host believes them to be.
  logic [15:0] m_lo, m_ph;
  logic [31:0] m_ftw;
  logic [1:0]  m_ws;
  logic        m_en;

  function automatic logic [15:0] m_read(input logic [6:0] a);
    case (a)
      7'h00: return m_lo;
      7'h01: return m_ftw[31:16];
      7'h02: return {13'd0, m_en, m_ws};
      7'h03: return m_ph;
      default: return 16'h0000;
    endcase
  endfunction

  task automatic model_reset();
    m_lo = 0; m_ph = 0; m_ftw = 0; m_ws = 0; m_en = 0;
  endtask

  typedef struct {
    bit          chk_miso;
    bit          is_read;
    logic [15:0] rd;
    logic [31:0] ftw;
    logic [15:0] ph;
    logic [1:0]  ws;
    logic        en;
  } exp_t;

  exp_t        frame_q[$];
  logic [31:0] upd_q[$];

  task automatic push_exp(input bit chk_miso, input bit is_read, input logic [15:0] rd);
    exp_t e;
    e.chk_miso = chk_miso; e.is_read = is_read; e.rd = rd;
    e.ftw = m_ftw; e.ph = m_ph; e.ws = m_ws; e.en = m_en;
    frame_q.push_back(e);
  endtask

  // One bit per sclk period, f_sclk = f_clk/8; mosi changes while sclk is low.
  task automatic spi_bits(input logic [23:0] fr, input int from, input int to);
    for (int i = from; i < to; i++) begin
      mosi = (i < 24) ? fr[23-i] : 1'($urandom_range(0, 1));
      #40 sclk = 1'b1;
      #40 sclk = 1'b0;
    end
  endtask

  task automatic frame(input bit rw, input logic [6:0] addr, input logic [15:0] data, input int nbits);
    logic [23:0] fr;
    logic [15:0] rd;
    fr = {rw, addr, data};
    rd = m_read(addr);
    if (!rw && nbits >= 24) begin
      case (addr)
        7'h00: m_lo = data;
        7'h01: begin m_ftw = {data, m_lo}; upd_q.push_back(m_ftw); end
        7'h02: begin m_ws = data[1:0]; m_en = data[2]; end
        7'h03: m_ph = data;
        default: ;
      endcase
    end
    push_exp(nbits >= 24, rw, rd);
    @(posedge clk);
    #($urandom_range(1, 8));
    cs_n = 1'b0;
    #50;
    spi_bits(fr, 0, nbits);
    #50 cs_n = 1'b1;
    #100;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ftw"}, ftw, 32'h0);
    chk({tag, "_ftw_update"}, ftw_update, 0);
    chk({tag, "_phase_ofs"}, phase_ofs, 0);
    chk({tag, "_wave_sel"}, wave_sel, 0);
    chk({tag, "_dds_en"}, dds_en, 0);
    chk({tag, "_miso"}, miso, 0);
    chk({tag, "_miso_oe"}, miso_oe, 0);
  endtask

  task automatic reset_idle();
    @(posedge clk);
    #3 rst = 1'b1;
    #1 check_reset_outputs("rst_idle");
    #20 rst = 1'b0;
    model_reset();
    #50;
  endtask

  // Reset lands during DATA of a write; the tail of that frame must not land.
  task automatic reset_mid_frame();
    logic [23:0] fr;
    fr = {1'b0, 7'h03, 16'h1111};
    @(posedge clk);
    #($urandom_range(1, 8));
    cs_n = 1'b0;
    #50;
    spi_bits(fr, 0, 14);
    #20 rst = 1'b1;
    #1 check_reset_outputs("rst_frame");
    #19 rst = 1'b0;
    model_reset();
    spi_bits(fr, 14, 24);
    push_exp(0, 0, 16'h0);
    #50 cs_n = 1'b1;
    #100;
  endtask

  // Monitor: ftw_update pulses against the expected commit queue.
  bit prev_upd = 0;
  always @(negedge clk) begin
    if (ftw_update === 1'b1) begin
      if (prev_upd) begin
        checks++; errors++;
        $display("FAIL ftw_update_width: got high for 2+ cycles, required 1");
      end else if (upd_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL ftw_update_unexpected: got pulse with ftw 0x%0h, required no pulse", ftw);
      end else begin
        chk("ftw_update_value", ftw, upd_q.pop_front());
      end
    end
    prev_upd = (ftw_update === 1'b1);
  end

  // Monitor: miso as seen by the host on each sclk rise.
  int          mbits;
  logic [15:0] mword;
  bit          m_nonzero, m_oe_bad;
  always @(posedge sclk) begin
    if (cs_n === 1'b0) begin
      mbits++;
      if (miso_oe !== 1'b1) m_oe_bad = 1;
      if (mbits >= 9 && mbits <= 24) mword = {mword[14:0], miso};
      else if (miso !== 1'b0) m_nonzero = 1;
    end
  end

  // Monitor: per-frame readback and register state after cs_n rises.
  always begin
    exp_t e;
    @(negedge cs_n);
    mbits = 0; mword = 0; m_nonzero = 0; m_oe_bad = 0;
    @(posedge cs_n);
    repeat (6) @(negedge clk);
    if (frame_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL frame_queue: got frame with no expectation, required one");
    end else begin
      e = frame_q.pop_front();
      if (e.chk_miso) begin
        chk("miso_data", mword, e.is_read ? e.rd : 16'h0);
        chk("miso_zero_outside_data", m_nonzero, 0);
        chk("miso_oe_in_frame", m_oe_bad, 0);
      end
      chk("ftw", ftw, e.ftw);
      chk("phase_ofs", phase_ofs, e.ph);
      chk("wave_sel", wave_sel, e.ws);
      chk("dds_en", dds_en, e.en);
    end
  end

  task automatic directed();
    frame(0, 7'h00, 16'h5678, 24);
    frame(0, 7'h01, 16'h1234, 24);
    frame(1, 7'h00, 16'h0000, 24);
    frame(1, 7'h01, 16'h0000, 24);
    frame(0, 7'h02, 16'h0006, 24);
    frame(1, 7'h02, 16'h0000, 24);
    frame(1, 7'h7F, 16'h0000, 24);
    frame(0, 7'h03, 16'hBEEF, 20);
    frame(0, 7'h03, 16'hBEEF, 24);
    frame(0, 7'h03, 16'h00A5, 30);
    frame(0, 7'h02, 16'hFFFF, 24);
    frame(1, 7'h02, 16'h0000, 24);
    reset_mid_frame();
    frame(0, 7'h03, 16'h2222, 24);
    frame(1, 7'h03, 16'h0000, 24);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, required end of stimulus");
    $fatal(1, "watchdog");
  end

  initial begin
    int sel, a, nb;
    model_reset();
    #12 check_reset_outputs("rst_start");
    #11 rst = 1'b0;
    #100;
    for (int pass = 0; pass < 2; pass++) begin
      directed();
      reset_idle();
    end
    for (int n = 0; n < 40; n++) begin
      a   = $urandom_range(0, 5);
      sel = $urandom_range(0, 3);
      nb  = (sel == 2) ? $urandom_range(9, 23) : (sel == 3) ? $urandom_range(25, 32) : 24;
      frame(1'($urandom_range(0, 1)), (a == 5) ? 7'h7F : 7'(a), 16'($urandom), nb);
    end
    #300;
    chk("pending_updates", upd_q.size(), 0);
    chk("pending_frames", frame_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
